// File: rtl/freq_divider.sv
// freq_divider: free-running N-bit counter producing a 2^N divided clock.
// clk256 is the counter MSB flop; tick flags the all-ones count.
module freq_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  output logic         clk256,
  output logic [N-1:0] count,
  output logic         tick
);

  logic [N-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + N'(1);
    end
  end

  // MSB taken straight from the register so the divided clock cannot glitch
  assign clk256 = cnt_q[N-1];
  assign count  = cnt_q;
  assign tick   = &cnt_q;

endmodule

// File: tb/tb_freq_divider.sv
// tb_freq_divider: directed table plus reset corner sequences
// across N=8, N=3 and N=1 builds.
module tb_freq_divider;

  logic       clk;
  logic       reset;
  logic       clk8, tick8;
  logic [7:0] count8;
  logic       clk3, tick3;
  logic [2:0] count3;
  logic       clk1, tick1;
  logic [0:0] count1;

  int n_run;
  int n_fail;
  int cur;
  bit bad_early;
  bit bad_tick;

  typedef struct {
    int k;
    int c8;
    bit h8;
    bit t8;
    int c3;
    int c1;
  } vec_t;

  vec_t tbl[13];

  freq_divider #(.N(8)) u_d8 (
    .clk(clk), .reset(reset),
    .clk256(clk8), .count(count8), .tick(tick8)
  );

  freq_divider #(.N(3)) u_d3 (
    .clk(clk), .reset(reset),
    .clk256(clk3), .count(count3), .tick(tick3)
  );

  freq_divider #(.N(1)) u_d1 (
    .clk(clk), .reset(reset),
    .clk256(clk1), .count(count1), .tick(tick1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      cur++;
    end
  endtask

  initial begin
    n_run     = 0;
    n_fail    = 0;
    bad_early = 1'b0;
    bad_tick  = 1'b0;

    tbl[0]  = '{k:   0, c8:   0, h8: 0, t8: 0, c3: 0, c1: 0};
    tbl[1]  = '{k:   1, c8:   1, h8: 0, t8: 0, c3: 1, c1: 1};
    tbl[2]  = '{k: 100, c8: 100, h8: 0, t8: 0, c3: 4, c1: 0};
    tbl[3]  = '{k: 127, c8: 127, h8: 0, t8: 0, c3: 7, c1: 1};
    tbl[4]  = '{k: 128, c8: 128, h8: 1, t8: 0, c3: 0, c1: 0};
    tbl[5]  = '{k: 254, c8: 254, h8: 1, t8: 0, c3: 6, c1: 0};
    tbl[6]  = '{k: 255, c8: 255, h8: 1, t8: 1, c3: 7, c1: 1};
    tbl[7]  = '{k: 256, c8:   0, h8: 0, t8: 0, c3: 0, c1: 0};
    tbl[8]  = '{k: 383, c8: 127, h8: 0, t8: 0, c3: 7, c1: 1};
    tbl[9]  = '{k: 384, c8: 128, h8: 1, t8: 0, c3: 0, c1: 0};
    tbl[10] = '{k: 511, c8: 255, h8: 1, t8: 1, c3: 7, c1: 1};
    tbl[11] = '{k: 512, c8:   0, h8: 0, t8: 0, c3: 0, c1: 0};
    tbl[12] = '{k: 600, c8:  88, h8: 0, t8: 0, c3: 0, c1: 0};

    reset = 1'b1;
    step();
    reset = 1'b0;
    cur = 0;

    for (int i = 0; i < 13; i++) begin
      while (cur < tbl[i].k) begin
        step();
        cur++;
        if (cur <= 127 && (clk8 !== 1'b0 || tick8 !== 1'b0))
          bad_early = 1'b1;
        if (tick8 !== (count8 == 8'd255))
          bad_tick = 1'b1;
      end
      chk($sformatf("cnt8@%0d", tbl[i].k), 32'(count8), 32'(tbl[i].c8));
      chk($sformatf("clk8@%0d", tbl[i].k), 32'(clk8), 32'(tbl[i].h8));
      chk($sformatf("tick8@%0d", tbl[i].k), 32'(tick8), 32'(tbl[i].t8));
      chk($sformatf("cnt3@%0d", tbl[i].k), 32'(count3), 32'(tbl[i].c3));
      chk($sformatf("clk3@%0d", tbl[i].k), 32'(clk3),
          32'(tbl[i].c3 >= 4));
      chk($sformatf("tick3@%0d", tbl[i].k), 32'(tick3),
          32'(tbl[i].c3 == 7));
      chk($sformatf("cnt1@%0d", tbl[i].k), 32'(count1), 32'(tbl[i].c1));
      chk($sformatf("clk1@%0d", tbl[i].k), 32'(clk1), 32'(tbl[i].c1));
      chk($sformatf("tick1@%0d", tbl[i].k), 32'(tick1), 32'(tbl[i].c1));
    end

    chk("early_low_window", 32'(bad_early), 32'd0);
    chk("tick_only_at_255", 32'(bad_tick), 32'd0);

    // reset mid-period while the divided clock is high
    adv(112);
    chk("pre_rst_cnt200", 32'(count8), 32'd200);
    chk("pre_rst_clk_hi", 32'(clk8), 32'd1);
    reset = 1'b1;
    step();
    chk("mid_rst_cnt", 32'(count8), 32'd0);
    chk("mid_rst_clk", 32'(clk8), 32'd0);
    chk("mid_rst_tick", 32'(tick8), 32'd0);
    reset = 1'b0;
    step();
    chk("resume_cnt1", 32'(count8), 32'd1);
    adv(126);
    chk("low_phase_end_cnt", 32'(count8), 32'd127);
    chk("low_phase_end_clk", 32'(clk8), 32'd0);
    step();
    chk("rise_after_128", 32'(clk8), 32'd1);

    // reset held across several edges starting at all-ones
    adv(127);
    chk("at255_tick", 32'(tick8), 32'd1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold_cnt8_%0d", i), 32'(count8), 32'd0);
      chk($sformatf("hold_tick8_%0d", i), 32'(tick8), 32'd0);
      chk($sformatf("hold_cnt3_%0d", i), 32'(count3), 32'd0);
      chk($sformatf("hold_clk1_%0d", i), 32'(clk1), 32'd0);
    end
    reset = 1'b0;
    step();
    chk("post_hold_cnt8", 32'(count8), 32'd1);
    chk("post_hold_cnt3", 32'(count3), 32'd1);

    // a reset pulse that misses every rising edge must be ignored
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step();
    chk("glitch_rst_cnt8", 32'(count8), 32'd2);
    chk("glitch_rst_cnt3", 32'(count3), 32'd2);
    chk("glitch_rst_clk1", 32'(clk1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_divider.md
FREQ_DIVIDER -- requirements
Module: freq_divider

Interface
REQ-001 The block SHALL have one parameter, N, default 8, giving the divider width: the output period is 2^N clk cycles (legal range 1..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 The block SHALL have port clk256, output, 1 bit: the divided clock, period 2^N clk cycles, 50% duty (256 cycles when N=8).
REQ-005 The block SHALL have port count, output, N bits: the current divider counter value.
REQ-006 The block SHALL have port tick, output, 1 bit: a one-cycle strobe marking the last cycle of each output period.

Function
REQ-007 The block SHALL hold an N-bit unsigned counter that increments by 1 on every rising clk edge while reset is low.
REQ-008 The counter SHALL wrap from 2^N-1 to 0 with no extra cycle and no stall.
REQ-009 count SHALL equal the counter register directly.
REQ-010 clk256 SHALL equal counter bit N-1, driven straight from a flop with no combinational logic, so it is glitch-free.
REQ-011 clk256 SHALL be low for counter values 0..2^(N-1)-1 and high for 2^(N-1)..2^N-1: 2^(N-1) cycles low, then 2^(N-1) cycles high.
REQ-012 tick SHALL be 1 exactly when the counter equals 2^N-1 (all ones) and 0 otherwise, giving one high cycle per 2^N cycles.
REQ-013 For N=1, clk256 SHALL toggle every cycle (divide by 2), and tick SHALL equal clk256.
REQ-014 The block SHALL have no enable or load input, and the counter SHALL never stop except under reset.
REQ-015 All outputs SHALL be defined (no X) from the first rising edge sampled with reset high.

Reset
REQ-016 On a rising clk edge with reset=1, the block SHALL set the counter to 0, so that count=0, clk256=0 and tick=0 after that edge.
REQ-017 Reset SHALL take priority over counting, including when asserted mid-period or at count=2^N-1; the next value after that edge SHALL be 0, not a wrap.
REQ-018 Asserting reset SHALL have no effect between clock edges.
REQ-019 While reset is held high, the block SHALL hold all outputs at their reset values.
REQ-020 On the first rising edge after reset falls, the counter SHALL go from 0 to 1.

Verification
REQ-021 Power-up with reset=1 for one edge, then deassert -> count=0 and clk256=0 immediately after the reset edge; count=1 after the next edge; count=k after k post-reset edges.
REQ-022 N=8, 10 ns clock, run 100 cycles after reset -> clk256 stays 0 throughout, tick stays 0, and count reaches 100.
REQ-023 N=8, run 600 cycles -> clk256 rises after edge 128 and falls after edge 256; the next rise is after edge 384; period 256, duty exactly 128/128.
REQ-024 N=8 -> tick is high only while count=255 (edges 255, 511, ...), and count reads 0 on the following edge.
REQ-025 N=8, assert reset for one edge while count=200 (clk256=1) -> count=0 and clk256=0 after that edge, then counting resumes at 1 with a full 128-cycle low phase.
REQ-026 N=1 and N=3 builds -> clk256 periods of 2 and 8 cycles, and tick high once per period on the all-ones count.
